// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: word load/store over a req/ack memory port, with
// stall/bubble generation, misalignment flagging and bus-timeout abort.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadIn,
   input  logic        MemWriteIn,
   input  logic [1:0]  WBIn,
   input  logic [31:0] ALUResultIn,
   input  logic [31:0] WriteDataIn,
   input  logic [4:0]  RegDstIn,
   input  logic        MemAck,
   input  logic [31:0] MemRData,
   output logic [1:0]  WBOut,
   output logic [31:0] MemReadDataOut,
   output logic [31:0] ALUResultOut,
   output logic [4:0]  RegDstOut,
   output logic        Stall,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWData,
   output logic        MisalignErr,
   output logic        BusErr
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             access, aligned, timeout_hit;

   assign ALUResultOut = ALUResultIn;
   assign RegDstOut    = RegDstIn;

   always_comb begin
      access         = MemReadIn | MemWriteIn;
      aligned        = (ALUResultIn[1:0] == 2'b00);
      timeout_hit    = (cnt == CNT_W'(TIMEOUT - 1));
      state_nxt      = state;
      Stall          = 1'b0;
      WBOut          = WBIn;
      MemReadDataOut = '0;
      MisalignErr    = 1'b0;
      BusErr         = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (access) begin
               WBOut = '0;
               if (!aligned) begin
                  MisalignErr = 1'b1;
               end else begin
                  Stall     = 1'b1;
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            Stall = 1'b1;
            WBOut = '0;
            // ack takes priority over the timeout in the same cycle
            if (MemAck || timeout_hit) state_nxt = S_DONE;
         end
         S_DONE: begin
            MemReadDataOut = rdata_q;
            BusErr         = err_q;
            if (err_q) WBOut = '0;
            state_nxt      = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         MemReq   <= 1'b0;
         MemWe    <= 1'b0;
         MemAddr  <= '0;
         MemWData <= '0;
         rdata_q  <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (access && aligned) begin
                  MemReq   <= 1'b1;
                  MemWe    <= MemWriteIn;
                  MemAddr  <= ALUResultIn;
                  MemWData <= WriteDataIn;
                  cnt      <= '0;
               end
            end
            S_WAIT: begin
               if (MemAck) begin
                  rdata_q <= MemWe ? '0 : MemRData;
                  err_q   <= 1'b0;
                  MemReq  <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  MemReq  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed literal cases, then randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_access_stage;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemReadIn, MemWriteIn;
   logic [1:0]  WBIn;
   logic [31:0] ALUResultIn, WriteDataIn;
   logic [4:0]  RegDstIn;
   logic        MemAck;
   logic [31:0] MemRData;
   logic [1:0]  WBOut;
   logic [31:0] MemReadDataOut, ALUResultOut;
   logic [4:0]  RegDstOut;
   logic        Stall, MemReq, MemWe;
   logic [31:0] MemAddr, MemWData;
   logic        MisalignErr, BusErr;

   int checks = 0;
   int errors = 0;
   bit model_on = 1'b0;
   bit exp_stall = 1'b0;

   // transaction-level model: an outstanding access and its completion slot
   bit          m_busy, m_done, m_err, m_req, m_we;
   int          m_waits;
   logic [31:0] m_data, m_addr, m_wdata;

   mem_access_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
      .WBIn(WBIn), .ALUResultIn(ALUResultIn), .WriteDataIn(WriteDataIn),
      .RegDstIn(RegDstIn), .MemAck(MemAck), .MemRData(MemRData),
      .WBOut(WBOut), .MemReadDataOut(MemReadDataOut), .ALUResultOut(ALUResultOut),
      .RegDstOut(RegDstOut), .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe),
      .MemAddr(MemAddr), .MemWData(MemWData), .MisalignErr(MisalignErr),
      .BusErr(BusErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_err = 0; m_req = 0; m_we = 0; m_waits = 0;
         m_data = '0; m_addr = '0; m_wdata = '0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_busy) begin
         m_waits++;
         if (MemAck) begin
            m_busy = 0; m_done = 1; m_err = 0; m_req = 0;
            m_data = m_we ? 32'h0 : MemRData;
         end else if (m_waits == TO) begin
            m_busy = 0; m_done = 1; m_err = 1; m_req = 0; m_data = '0;
         end
      end else if ((MemReadIn || MemWriteIn) && ALUResultIn[1:0] == 2'b00) begin
         m_busy = 1; m_waits = 0; m_req = 1; m_we = MemWriteIn;
         m_addr = ALUResultIn; m_wdata = WriteDataIn;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         bit          e_stall, e_mis, e_bus, acc, mis;
         logic [1:0]  e_wb;
         logic [31:0] e_rd;
         acc = MemReadIn || MemWriteIn;
         mis = ALUResultIn[1:0] != 2'b00;
         e_stall = 0; e_mis = 0; e_bus = 0; e_wb = WBIn; e_rd = '0;
         if (m_done) begin
            e_rd = m_data; e_bus = m_err; e_wb = m_err ? 2'b00 : WBIn;
         end else if (m_busy) begin
            e_stall = 1; e_wb = 2'b00;
         end else if (acc) begin
            e_wb = 2'b00; e_mis = mis; e_stall = !mis;
         end
         check("m_stall", 32'(Stall), 32'(e_stall));
         check("m_wbout", 32'(WBOut), 32'(e_wb));
         check("m_misalign", 32'(MisalignErr), 32'(e_mis));
         check("m_buserr", 32'(BusErr), 32'(e_bus));
         if (!m_busy) check("m_rdata", MemReadDataOut, e_rd);
         check("m_alu_pass", ALUResultOut, ALUResultIn);
         check("m_rd_pass", 32'(RegDstOut), 32'(RegDstIn));
         check("m_req", 32'(MemReq), 32'(m_req));
         if (m_req) begin
            check("m_we", 32'(MemWe), 32'(m_we));
            check("m_addr", MemAddr, m_addr);
            check("m_wdata", MemWData, m_wdata);
         end
         exp_stall = e_stall;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MemReadIn = 0; MemWriteIn = 0; WBIn = 2'b00; ALUResultIn = '0;
      WriteDataIn = '0; RegDstIn = '0; MemAck = 0; MemRData = '0;
   endtask

   // Issues one aligned access and lets it run to completion; ack_after = 0 never acks.
   task automatic mem_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] wb, input int ack_after, input logic [31:0] rdata,
                         output int stalls, output int waits, output logic [31:0] d_data,
                         output logic d_bus, output logic [1:0] d_wb);
      bit finished = 0;
      MemReadIn = !wr; MemWriteIn = wr; ALUResultIn = addr; WriteDataIn = wdata;
      WBIn = wb; RegDstIn = 5'd7;
      stalls = 0; waits = 0; d_data = 'x; d_bus = 'x; d_wb = 'x;
      for (int c = 0; c < 40 && !finished; c++) begin
         @(negedge clk);
         if (MemReq) begin
            waits++;
            check("op_addr", MemAddr, addr);
            check("op_we", 32'(MemWe), 32'(wr));
            if (wr) check("op_wdata", MemWData, wdata);
            MemAck = (waits == ack_after);
            MemRData = MemAck ? rdata : $urandom;
         end else begin
            MemAck = 0;
         end
         if (Stall) begin
            stalls++;
            check("op_bubble", 32'(WBOut), 32'(0));
         end else begin
            d_data = MemReadDataOut; d_bus = BusErr; d_wb = WBOut;
            finished = 1;
         end
         cyc();
         MemAck = 0;
      end
      if (!finished) check("op_bound", 32'(0), 32'(1));
      idle_inputs();
   endtask

   initial begin
      int          st, wt;
      logic [31:0] dd;
      logic        db;
      logic [1:0]  dw;
      bit          rst_prev;

      idle_inputs();
      rst = 1;
      cyc();
      model_on = 1;
      @(negedge clk);
      check("rst_req", 32'(MemReq), 32'(0));
      check("rst_stall", 32'(Stall), 32'(0));
      check("rst_addr", MemAddr, 32'h0);
      cyc();
      rst = 0;

      // ALU op passes straight through
      WBIn = 2'b10; ALUResultIn = 32'h1234;
      @(negedge clk);
      check("alu_stall", 32'(Stall), 32'(0));
      check("alu_wb", 32'(WBOut), 32'(2'b10));
      check("alu_pass", ALUResultOut, 32'h1234);
      check("alu_req", 32'(MemReq), 32'(0));
      cyc();
      idle_inputs();

      mem_op(0, 32'h100, 32'h0, 2'b11, 1, 32'hDEADBEEF, st, wt, dd, db, dw);
      check("ld_stalls", 32'(st), 32'(2));
      check("ld_data", dd, 32'hDEADBEEF);
      check("ld_wb", 32'(dw), 32'(2'b11));
      check("ld_bus", 32'(db), 32'(0));

      mem_op(1, 32'h200, 32'hCAFEF00D, 2'b01, 3, 32'h5555AAAA, st, wt, dd, db, dw);
      check("st_stalls", 32'(st), 32'(4));
      check("st_data", dd, 32'h0);
      check("st_wb", 32'(dw), 32'(2'b01));

      MemReadIn = 1; ALUResultIn = 32'h103; WBIn = 2'b11;
      @(negedge clk);
      check("mis_flag", 32'(MisalignErr), 32'(1));
      check("mis_wb", 32'(WBOut), 32'(0));
      check("mis_stall", 32'(Stall), 32'(0));
      cyc();
      @(negedge clk);
      check("mis_req", 32'(MemReq), 32'(0));
      cyc();
      idle_inputs();

      mem_op(0, 32'h40, 32'h0, 2'b11, 0, 32'h0, st, wt, dd, db, dw);
      check("to_waits", 32'(wt), 32'(TO));
      check("to_stalls", 32'(st), 32'(TO + 1));
      check("to_bus", 32'(db), 32'(1));
      check("to_wb", 32'(dw), 32'(0));
      @(negedge clk);
      check("to_back_idle", 32'(BusErr), 32'(0));
      cyc();

      mem_op(0, 32'h44, 32'h0, 2'b10, TO, 32'h600DF00D, st, wt, dd, db, dw);
      check("lateack_bus", 32'(db), 32'(0));
      check("lateack_data", dd, 32'h600DF00D);
      check("lateack_wb", 32'(dw), 32'(2'b10));

      // reset in the 2nd WAIT cycle, late ack must be ignored
      MemReadIn = 1; ALUResultIn = 32'h80; WBIn = 2'b11;
      cyc();
      cyc();
      rst = 1;
      cyc();
      rst = 0;
      idle_inputs();
      @(negedge clk);
      check("rw_req", 32'(MemReq), 32'(0));
      check("rw_stall", 32'(Stall), 32'(0));
      cyc();
      MemAck = 1; MemRData = 32'hBAD0BAD0;
      @(negedge clk);
      check("rw_ack_stall", 32'(Stall), 32'(0));
      cyc();
      MemAck = 0;
      @(negedge clk);
      check("rw_ack_rdata", MemReadDataOut, 32'h0);
      check("rw_ack_req", 32'(MemReq), 32'(0));
      cyc();

      rst_prev = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!exp_stall || rst_prev) begin
            int op = $urandom_range(0, 2);
            MemReadIn  = (op == 0);
            MemWriteIn = (op == 1);
            ALUResultIn = $urandom;
            if ($urandom_range(0, 3) != 0) ALUResultIn[1:0] = 2'b00;
            WriteDataIn = $urandom;
            WBIn = 2'($urandom);
            RegDstIn = 5'($urandom);
         end
         rst = ($urandom_range(0, 299) == 0);
         rst_prev = rst;
         MemAck = ($urandom_range(0, 2) == 0);
         MemRData = $urandom;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
